// File: rtl/num_match_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : num_match_pkg
// Purpose : Shared types and constants for the num_match_unit compare block.
//           Letter-range constants, the reporting-mode encoding and the
//           letter code type.
// Rev     : 1.0  initial release
// ============================================================================
package num_match_pkg;

  localparam int LETTER_W   = 5;
  localparam int LETTER_MAX = 25;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } match_mode_e;

  typedef logic [LETTER_W-1:0] letter_t;

endpackage
`default_nettype wire

// File: rtl/num_match_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : num_match_unit_if
// Purpose : Config / sample / result bundle for num_match_unit.
//   i_cfg_we, i_cfg_sel, i_cfg_val, i_cfg_en : channel config write
//   i_mode                                   : 0 level, 1 edge reporting
//   i_d, i_d_valid                           : qualified sample stream
//   i_clr_cnt, i_rd_sel                      : counter clear / readback select
//   o_match, o_match_valid, o_any, o_first_idx, o_hit_cnt : results
//   master = stimulus side, slave = the compare unit.
// Rev     : 1.0  initial release
// ============================================================================
interface num_match_unit_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);

  logic                i_cfg_we;
  logic [IDX_W-1:0]    i_cfg_sel;
  logic [WIDTH-1:0]    i_cfg_val;
  logic                i_cfg_en;
  logic                i_mode;
  logic [WIDTH-1:0]    i_d;
  logic                i_d_valid;
  logic                i_clr_cnt;
  logic [IDX_W-1:0]    i_rd_sel;
  logic [CHANNELS-1:0] o_match;
  logic                o_match_valid;
  logic                o_any;
  logic [IDX_W-1:0]    o_first_idx;
  logic [CNT_W-1:0]    o_hit_cnt;

  modport master (
    output i_cfg_we, i_cfg_sel, i_cfg_val, i_cfg_en, i_mode,
    output i_d, i_d_valid, i_clr_cnt, i_rd_sel,
    input  o_match, o_match_valid, o_any, o_first_idx, o_hit_cnt
  );

  modport slave (
    input  i_cfg_we, i_cfg_sel, i_cfg_val, i_cfg_en, i_mode,
    input  i_d, i_d_valid, i_clr_cnt, i_rd_sel,
    output o_match, o_match_valid, o_any, o_first_idx, o_hit_cnt
  );

endinterface
`default_nettype wire

// File: rtl/num_match_unit_chan.sv
`default_nettype none
// ============================================================================
// Module  : num_match_chan
// Purpose : One compare channel: target/enable registers, onset history bit
//           and saturating hit counter.
//   clk, rst            : clock, synchronous active-high reset
//   i_cfg_we            : config write aimed at this channel
//   i_cfg_val, i_cfg_en : new target / enable
//   i_mode              : level or edge reporting
//   i_d, i_d_valid      : sample
//   i_clr_cnt           : zero the hit counter
//   o_raw_hit           : sample equals target on an enabled channel
//   o_match_next        : value loaded into the top-level match register
//   o_cnt               : hit counter
// Rev     : 1.0  initial release
// ============================================================================
module num_match_chan
  import num_match_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_cfg_we,
  input  wire logic [WIDTH-1:0] i_cfg_val,
  input  wire logic             i_cfg_en,
  input  wire match_mode_e      i_mode,
  input  wire logic [WIDTH-1:0] i_d,
  input  wire logic             i_d_valid,
  input  wire logic             i_clr_cnt,
  output logic                  o_raw_hit,
  output logic                  o_match_next,
  output logic [CNT_W-1:0]      o_cnt
);

  logic [WIDTH-1:0] r_target;
  logic             r_en;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_raw;
  logic             w_match;

  // Compare uses the registered config, so a same-cycle write only affects
  // later samples.
  assign w_raw   = i_d_valid & r_en & (i_d == r_target);
  assign w_match = (i_mode == MODE_EDGE) ? (w_raw & ~r_prev) : w_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= '0;
      r_en     <= 1'b0;
      r_prev   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (i_cfg_we) begin
        r_target <= i_cfg_val;
        r_en     <= i_cfg_en;
      end
      // Disabling re-arms onset detection; invalid samples hold history so
      // gaps in the stream do not produce a fresh onset.
      if (i_cfg_we && !i_cfg_en) begin
        r_prev <= 1'b0;
      end else if (i_d_valid) begin
        r_prev <= w_raw;
      end
      if (i_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_raw_hit    = w_raw;
  assign o_match_next = w_match;
  assign o_cnt        = r_cnt;

endmodule
`default_nettype wire

// File: rtl/num_match_unit.sv
`default_nettype none
// ============================================================================
// Module  : num_match_unit
// Purpose : Multi-channel registered equality detector for letter/position
//           codes with per-channel saturating hit counters.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : num_match_unit_if slave (config, sample, results, readback)
// Rev     : 1.0  initial release
// ============================================================================
module num_match_unit
  import num_match_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  num_match_unit_if.slave   bus
);

  logic [CHANNELS-1:0] w_raw_hit;
  logic [CHANNELS-1:0] w_match_next;
  logic [CNT_W-1:0]    w_cnt [CHANNELS];
  logic [IDX_W-1:0]    w_first;
  logic [CNT_W-1:0]    w_hit_cnt;
  match_mode_e         w_mode;

  logic [CHANNELS-1:0] r_match;
  logic                r_match_valid;
  logic                r_any;
  logic [IDX_W-1:0]    r_first_idx;

  assign w_mode = match_mode_e'(bus.i_mode);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic w_we;
      // Selects beyond the channel count never decode, so such writes drop.
      assign w_we = bus.i_cfg_we && (bus.i_cfg_sel == IDX_W'(gi));

      num_match_chan #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_we     (w_we),
        .i_cfg_val    (bus.i_cfg_val),
        .i_cfg_en     (bus.i_cfg_en),
        .i_mode       (w_mode),
        .i_d          (bus.i_d),
        .i_d_valid    (bus.i_d_valid),
        .i_clr_cnt    (bus.i_clr_cnt),
        .o_raw_hit    (w_raw_hit[gi]),
        .o_match_next (w_match_next[gi]),
        .o_cnt        (w_cnt[gi])
      );
    end
  endgenerate

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_first = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_match_next[k]) begin
        w_first = IDX_W'(k);
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    w_hit_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.i_rd_sel == IDX_W'(k)) begin
        w_hit_cnt = w_cnt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match       <= '0;
      r_match_valid <= 1'b0;
      r_any         <= 1'b0;
      r_first_idx   <= '0;
    end else begin
      r_match       <= w_match_next;
      r_match_valid <= bus.i_d_valid;
      r_any         <= |w_match_next;
      r_first_idx   <= w_first;
    end
  end

  assign bus.o_match       = r_match;
  assign bus.o_match_valid = r_match_valid;
  assign bus.o_any         = r_any;
  assign bus.o_first_idx   = r_first_idx;
  assign bus.o_hit_cnt     = w_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_num_match_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_num_match_unit
// Purpose : Scoreboard bench for num_match_unit (CHANNELS=4, WIDTH=5,
//           CNT_W=2, IDX_W=3). Directed vectors with hand-computed results.
// Rev     : 1.0  initial release
// ============================================================================
module tb_num_match_unit;

  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 2;
  localparam int IDX_W    = 3;

  typedef struct {
    logic [3:0] m;
    logic       v;
    logic       a;
    logic [2:0] f;
    logic [1:0] c;
    string      n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  num_match_unit_if #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) bus ();

  num_match_unit #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drv(input logic r, input logic we, input logic [2:0] sel,
                     input logic [4:0] val, input logic en, input logic md,
                     input logic [4:0] d, input logic dv, input logic clr,
                     input logic [2:0] rd);
    @(negedge clk);
    rst           = r;
    bus.i_cfg_we  = we;
    bus.i_cfg_sel = sel;
    bus.i_cfg_val = val;
    bus.i_cfg_en  = en;
    bus.i_mode    = md;
    bus.i_d       = d;
    bus.i_d_valid = dv;
    bus.i_clr_cnt = clr;
    bus.i_rd_sel  = rd;
  endtask

  task automatic expect_out(input logic [3:0] m, input logic v, input logic a,
                            input logic [2:0] f, input logic [1:0] c,
                            input string n);
    exp_t e;
    e.m = m; e.v = v; e.a = a; e.f = f; e.c = c; e.n = n;
    q.push_back(e);
  endtask

  // Monitor: one expectation per driven cycle, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.o_match !== e.m || bus.o_match_valid !== e.v ||
            bus.o_any !== e.a || bus.o_first_idx !== e.f ||
            bus.o_hit_cnt !== e.c) begin
          bad++;
          $display("FAIL %s: got match=%b valid=%b any=%b first=%0d cnt=%0d, want match=%b valid=%b any=%b first=%0d cnt=%0d",
                   e.n, bus.o_match, bus.o_match_valid, bus.o_any,
                   bus.o_first_idx, bus.o_hit_cnt, e.m, e.v, e.a, e.f, e.c);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.i_cfg_we = 0; bus.i_cfg_sel = 0; bus.i_cfg_val = 0; bus.i_cfg_en = 0;
    bus.i_mode = 0; bus.i_d = 0; bus.i_d_valid = 0; bus.i_clr_cnt = 0;
    bus.i_rd_sel = 0;

    //  rst we sel val en md  d  dv clr rd
    drv(1, 0, 0, 0,  0, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 0, "reset");
    drv(0, 1, 0, 3,  1, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 0, "cfg_ch0");
    drv(0, 1, 2, 3,  1, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 0, "cfg_ch2");
    drv(0, 1, 1, 7,  1, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 0, "cfg_ch1");
    drv(0, 0, 0, 0,  0, 0, 3,  1, 0, 0); expect_out(4'b0101, 1, 1, 0, 1, "level_d3");

    // Edge mode: only the first of a run (and not after a gap) reports.
    drv(0, 0, 0, 0,  0, 1, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 1, "edge_onset");
    drv(0, 0, 0, 0,  0, 1, 7,  1, 0, 1); expect_out(4'b0000, 1, 0, 0, 1, "edge_hold1");
    drv(0, 0, 0, 0,  0, 1, 7,  1, 0, 1); expect_out(4'b0000, 1, 0, 0, 1, "edge_hold2");
    drv(0, 0, 0, 0,  0, 1, 7,  0, 0, 1); expect_out(4'b0000, 0, 0, 0, 1, "edge_gap");
    drv(0, 0, 0, 0,  0, 1, 7,  1, 0, 1); expect_out(4'b0000, 1, 0, 0, 1, "edge_no_rearm");

    // Level mode saturation with a 2-bit counter.
    drv(0, 0, 0, 0,  0, 0, 0,  0, 1, 1); expect_out(4'b0000, 0, 0, 0, 0, "clr_idle");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 1, "sat_1");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 2, "sat_2");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 3, "sat_3");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 3, "sat_4");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 3, "sat_5");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 1, 1); expect_out(4'b0010, 1, 1, 1, 0, "clr_with_hit");
    drv(0, 0, 0, 0,  0, 0, 7,  1, 0, 1); expect_out(4'b0010, 1, 1, 1, 1, "count_resume");

    // Write-after-compare on ch0.
    drv(0, 1, 0, 9,  1, 0, 3,  1, 0, 0); expect_out(4'b0101, 1, 1, 0, 1, "wr_same_cycle");
    drv(0, 0, 0, 0,  0, 0, 3,  1, 0, 0); expect_out(4'b0100, 1, 1, 2, 1, "wr_old_gone");
    drv(0, 0, 0, 0,  0, 0, 9,  1, 0, 0); expect_out(4'b0001, 1, 1, 0, 2, "wr_new_target");

    // Disabled channel and out-of-range select.
    drv(0, 1, 3, 0,  0, 0, 0,  0, 0, 3); expect_out(4'b0000, 0, 0, 0, 0, "cfg_ch3_off");
    drv(0, 0, 0, 0,  0, 0, 0,  1, 0, 3); expect_out(4'b0000, 1, 0, 0, 0, "disabled_d0");
    drv(0, 1, 5, 0,  1, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 2, "cfg_sel5");
    drv(0, 0, 0, 0,  0, 0, 0,  1, 0, 4); expect_out(4'b0000, 1, 0, 0, 0, "sel5_ignored");

    // Shared target: lowest matching index reported.
    drv(0, 1, 3, 3,  1, 0, 0,  0, 0, 2); expect_out(4'b0000, 0, 0, 0, 2, "cfg_ch3_3");
    drv(0, 0, 0, 0,  0, 0, 3,  1, 0, 2); expect_out(4'b1100, 1, 1, 2, 3, "shared_target");

    // Disabling ch2 clears its history, so re-enabling gives a fresh onset.
    drv(0, 1, 2, 3,  0, 1, 3,  1, 0, 3); expect_out(4'b0000, 1, 0, 0, 1, "edge_disable");
    drv(0, 1, 2, 3,  1, 1, 0,  0, 0, 3); expect_out(4'b0000, 0, 0, 0, 1, "edge_reenable");
    drv(0, 0, 0, 0,  0, 1, 3,  1, 0, 3); expect_out(4'b0100, 1, 1, 2, 1, "edge_rearmed");

    // Out-of-letter-range value compares normally.
    drv(0, 1, 0, 31, 1, 0, 0,  0, 0, 0); expect_out(4'b0000, 0, 0, 0, 2, "cfg_ch0_31");
    drv(0, 0, 0, 0,  0, 0, 31, 1, 0, 0); expect_out(4'b0001, 1, 1, 0, 3, "d31");

    // Reset dominates valid data and a config write.
    drv(1, 1, 0, 3,  1, 0, 3,  1, 0, 2); expect_out(4'b0000, 0, 0, 0, 0, "mid_reset");
    drv(0, 0, 0, 0,  0, 0, 3,  1, 0, 0); expect_out(4'b0000, 1, 0, 0, 0, "post_reset");

    drv(0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/num_match_unit.md
Name: num_match_unit

Overview:
- Parametrised, registered multi-channel equality detector for letter/position codes.
- Each channel holds a programmable target value and an enable. Channels compare against a valid-qualified input stream and report a match vector, an any-match flag and the lowest matching index.
- Each channel keeps a saturating hit counter. Level or edge (match-onset) reporting is selectable.
- Sits between the rotor/position datapath and the stepping/notch control logic.

Parameters:
- WIDTH, 5, bit width of compared values and targets.
- CHANNELS, 4, number of independent compare channels (min 1).
- CNT_W, 8, width of each per-channel hit counter.
- IDX_W, $clog2(CHANNELS) (min 1), width of channel select/index fields (derived, not overridden).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- CFG_WE  in  1  write strobe for channel config.
- CFG_SEL  in  IDX_W  channel written when CFG_WE=1.
- CFG_VAL  in  WIDTH  target value written.
- CFG_EN  in  1  channel enable written.
- MODE  in  1  0 = level reporting, 1 = edge (onset) reporting.
- D  in  WIDTH  sample to compare.
- D_VALID  in  1  sample qualifier.
- CLR_CNT  in  1  clears all hit counters.
- RD_SEL  in  IDX_W  counter readback select.
- MATCH  out  CHANNELS  registered per-channel match.
- MATCH_VALID  out  1  registered copy of D_VALID.
- ANY  out  1  OR of MATCH.
- FIRST_IDX  out  IDX_W  lowest set bit of MATCH; 0 when ANY=0.
- HIT_CNT  out  CNT_W  counter of channel RD_SEL (combinational mux of registers).

Behaviour:
- Reset (synchronous, RST=1 at edge):
  - All targets 0, all enables 0, edge history 0, counters 0.
  - MATCH=0, MATCH_VALID=0, ANY=0, FIRST_IDX=0.
  - RST dominates all other inputs in that cycle.
- Latency: 1 cycle. A sample at edge N is reflected in MATCH/ANY/FIRST_IDX/MATCH_VALID after edge N.
- Raw hit for channel i: D_VALID & EN[i] & (D == TARGET[i]).
- Level mode: MATCH[i] = raw hit.
- Edge mode: MATCH[i] = raw hit & ~PREV[i].
  - PREV[i] updates to the raw-hit value only on cycles with D_VALID=1. Invalid cycles leave PREV unchanged, so gaps do not re-arm.
- D_VALID=0: MATCH=0, ANY=0, FIRST_IDX=0, MATCH_VALID=0 next cycle.
- MODE change takes effect on the next sample. PREV is tracked continuously in both modes.
- Config write:
  - On CFG_WE, TARGET[CFG_SEL] and EN[CFG_SEL] update at the edge.
  - A compare in the same cycle uses the old config (write-after-compare).
  - Writing EN=0 also clears PREV for that channel.
  - CFG_SEL >= CHANNELS: write ignored.
- Hit counters:
  - Increment by 1 when MATCH[i] is asserted into the register, so counting follows the mode.
  - Saturate at all-ones; no wrap.
  - CLR_CNT zeroes all counters; CLR_CNT and a hit in the same cycle gives 0.
- Readback: RD_SEL >= CHANNELS returns 0.
- Multiple channels may share a target. All matching bits assert, and FIRST_IDX picks the lowest index.
- D values outside the letter range (26..31 at WIDTH=5) are compared normally; no range check.

Decomposition:
- Package num_match_pkg:
  - LETTER_W=5, LETTER_MAX=25.
  - Typedef match_mode_e {MODE_LEVEL=0, MODE_EDGE=1}.
  - Typedef letter_t = logic [LETTER_W-1:0].
- Sub-module num_match_chan, one per channel via generate:
  - Holds the target/enable regs, the PREV bit and the saturating counter.
  - Outputs the raw hit and the next MATCH bit.
- Top level holds output regs, the priority encoder and the readback mux.

Test Plan:
- Reset then program ch0=3 EN, ch2=3 EN, ch1=7 EN; MODE=0; D=3 valid -> next cycle MATCH=4'b0101, ANY=1, FIRST_IDX=0, MATCH_VALID=1.
- Edge mode: ch1=7 EN; D=7 valid three cycles, one invalid cycle, then D=7 valid -> MATCH[1] high only on the first sample; HIT_CNT(RD_SEL=1)=1.
- Level mode with CNT_W=2: D=7 valid five cycles -> HIT_CNT for ch1 reads 1,2,3,3,3 (saturates). Assert CLR_CNT with a hit in the same cycle -> 0.
- Same-cycle config: ch0 target 3, D=3 valid while CFG_WE rewrites ch0 to 9 -> MATCH[0]=1 this sample; next D=3 -> MATCH[0]=0.
- Disabled channel: ch3 target 0 with EN=0, D=0 valid -> MATCH[3]=0, ANY=0, FIRST_IDX=0. CFG_SEL=5 write ignored (for a CHANNELS=4 instance with IDX_W raised to 3).
- Mid-operation RST with D_VALID=1, D=3, CFG_WE=1 -> all outputs 0 next cycle, counters 0, all enables 0.
